// File: rtl/router_pkg.sv
// Shared types and constants for the 1x3 router packet-reception controller.
package router_pkg;

  typedef enum logic [2:0] {
    DECODE_ADDRESS     = 3'd0,
    LOAD_FIRST_DATA    = 3'd1,
    LOAD_DATA          = 3'd2,
    LOAD_PARITY        = 3'd3,
    FIFO_FULL_STATE    = 3'd4,
    LOAD_AFTER_FULL    = 3'd5,
    WAIT_TILL_EMPTY    = 3'd6,
    CHECK_PARITY_ERROR = 3'd7
  } state_e;

  localparam logic [1:0]  ADDR_INVALID = 2'b11;
  localparam int unsigned NUM_PORTS    = 3;

  // Per-port flag lookup; the invalid address selects nothing.
  function automatic logic port_sel(input logic [NUM_PORTS-1:0] flags, input logic [1:0] idx);
    logic r;
    case (idx)
      2'd0:    r = flags[0];
      2'd1:    r = flags[1];
      2'd2:    r = flags[2];
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/router_fsm_wdog.sv
// Watchdog for router_fsm: counts cycles spent waiting and flags expiry.
module router_fsm_wdog
  import router_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 30
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic run_i,
  input  logic suppress_i,
  output logic expire_o,
  output logic timeout_err_o
);

  localparam int unsigned     CW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0]   LIMIT = CW'(TIMEOUT_CYCLES);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;

  always_comb begin
    expire_o = run_i && (cnt_q == LIMIT);
    cnt_d    = '0;
    if (run_i) cnt_d = expire_o ? cnt_q : cnt_q + CW'(1);
    // A soft reset on the same edge takes precedence, so no error is reported.
    err_d    = expire_o && !suppress_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign timeout_err_o = err_q;

endmodule

// File: rtl/router_fsm.sv
// Packet-reception controller for the 1x3 router.
// Optional watchdog on WAIT_TILL_EMPTY / FIFO_FULL_STATE: define ROUTER_FSM_TIMEOUT_EN.
module router_fsm
  import router_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 30
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       pkt_valid,
  input  logic [1:0] data_in,
  input  logic       parity_done,
  input  logic       low_pkt_valid,
  input  logic       fifo_full,
  input  logic       fifo_empty_0,
  input  logic       fifo_empty_1,
  input  logic       fifo_empty_2,
  input  logic       soft_reset_0,
  input  logic       soft_reset_1,
  input  logic       soft_reset_2,
  output logic       detect_add,
  output logic       lfd_state,
  output logic       ld_state,
  output logic       laf_state,
  output logic       full_state,
  output logic       write_enb_reg,
  output logic       rst_int_reg,
  output logic       busy,
  output logic       timeout_err
);

  state_e     state_q, state_d;
  logic [1:0] addr_q, addr_d;
  logic [1:0] sel_idx;
  logic       fifo_empty_sel, soft_reset_sel, wdog_expire;

  // The live header selects the port while decoding; afterwards the latched one does.
  assign sel_idx        = (state_q == DECODE_ADDRESS) ? data_in : addr_q;
  assign fifo_empty_sel = port_sel({fifo_empty_2, fifo_empty_1, fifo_empty_0}, sel_idx);
  assign soft_reset_sel = port_sel({soft_reset_2, soft_reset_1, soft_reset_0}, sel_idx);

`ifdef ROUTER_FSM_TIMEOUT_EN
  logic wdog_run;
  assign wdog_run = (state_q == WAIT_TILL_EMPTY) || (state_q == FIFO_FULL_STATE);

  router_fsm_wdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wdog (
    .clk_i        (clock),
    .rst_i        (reset),
    .run_i        (wdog_run),
    .suppress_i   (soft_reset_sel),
    .expire_o     (wdog_expire),
    .timeout_err_o(timeout_err)
  );
`else
  logic unused_timeout_cycles;
  assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
  assign wdog_expire           = 1'b0;
  assign timeout_err           = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    if (state_q == DECODE_ADDRESS && pkt_valid) addr_d = data_in;

    if (state_q != DECODE_ADDRESS && soft_reset_sel) begin
      state_d = DECODE_ADDRESS;
    end else if (wdog_expire) begin
      state_d = DECODE_ADDRESS;
    end else begin
      case (state_q)
        DECODE_ADDRESS:
          if (pkt_valid && data_in != ADDR_INVALID)
            state_d = fifo_empty_sel ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
        LOAD_FIRST_DATA:    state_d = LOAD_DATA;
        LOAD_DATA:
          if (fifo_full)       state_d = FIFO_FULL_STATE;
          else if (!pkt_valid) state_d = LOAD_PARITY;
        FIFO_FULL_STATE:
          if (!fifo_full) state_d = LOAD_AFTER_FULL;
        LOAD_AFTER_FULL:
          if (parity_done)        state_d = DECODE_ADDRESS;
          else if (low_pkt_valid) state_d = LOAD_PARITY;
          else                    state_d = LOAD_DATA;
        LOAD_PARITY:        state_d = CHECK_PARITY_ERROR;
        CHECK_PARITY_ERROR: state_d = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
        WAIT_TILL_EMPTY:
          if (fifo_empty_sel) state_d = LOAD_FIRST_DATA;
        default:            state_d = DECODE_ADDRESS;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= DECODE_ADDRESS;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  always_comb begin
    detect_add    = (state_q == DECODE_ADDRESS);
    lfd_state     = (state_q == LOAD_FIRST_DATA);
    ld_state      = (state_q == LOAD_DATA);
    laf_state     = (state_q == LOAD_AFTER_FULL);
    full_state    = (state_q == FIFO_FULL_STATE);
    rst_int_reg   = (state_q == CHECK_PARITY_ERROR);
    write_enb_reg = (state_q == LOAD_DATA) || (state_q == LOAD_PARITY) ||
                    (state_q == LOAD_AFTER_FULL);
    busy          = !((state_q == DECODE_ADDRESS) || (state_q == LOAD_DATA));
  end

endmodule

// File: tb/tb_router_fsm.sv
// Scoreboard bench for router_fsm: directed packet scenarios plus random traffic vs. a reference model.
module tb_router_fsm;

  localparam int unsigned TO = 30;

  logic       clock = 1'b0;
  logic       reset, pkt_valid, parity_done, low_pkt_valid, fifo_full;
  logic [1:0] data_in;
  logic       fifo_empty_0, fifo_empty_1, fifo_empty_2;
  logic       soft_reset_0, soft_reset_1, soft_reset_2;
  logic       detect_add, lfd_state, ld_state, laf_state, full_state;
  logic       write_enb_reg, rst_int_reg, busy, timeout_err;

  router_fsm #(.TIMEOUT_CYCLES(TO)) dut (
    .clock(clock), .reset(reset), .pkt_valid(pkt_valid), .data_in(data_in),
    .parity_done(parity_done), .low_pkt_valid(low_pkt_valid), .fifo_full(fifo_full),
    .fifo_empty_0(fifo_empty_0), .fifo_empty_1(fifo_empty_1), .fifo_empty_2(fifo_empty_2),
    .soft_reset_0(soft_reset_0), .soft_reset_1(soft_reset_1), .soft_reset_2(soft_reset_2),
    .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state),
    .laf_state(laf_state), .full_state(full_state), .write_enb_reg(write_enb_reg),
    .rst_int_reg(rst_int_reg), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clock = ~clock;

  typedef enum {P_DA, P_LFD, P_LD, P_LP, P_FFS, P_LAF, P_WTE, P_CPE} phase_t;
  typedef struct { logic [8:0] outs; string name; } exp_t;

  exp_t        sb[$];
  int unsigned total_cnt = 0;
  int unsigned pass_cnt  = 0;
  int unsigned cyc       = 0;

  phase_t      m_ph   = P_DA;
  logic [1:0]  m_addr = 2'd0;
  int unsigned m_wait = 0;
  logic        m_terr = 1'b0;

  // {detect_add, lfd, ld, laf, full, write_enb, rst_int, busy, timeout_err}
  function automatic logic [8:0] expect_outs(phase_t p, logic terr);
    logic [8:0] v;
    v    = '0;
    v[8] = (p == P_DA);
    v[7] = (p == P_LFD);
    v[6] = (p == P_LD);
    v[5] = (p == P_LAF);
    v[4] = (p == P_FFS);
    v[3] = (p == P_LD) || (p == P_LP) || (p == P_LAF);
    v[2] = (p == P_CPE);
    v[1] = !(p == P_DA || p == P_LD);
    v[0] = terr;
    return v;
  endfunction

  function automatic logic pick(logic a0, logic a1, logic a2, logic [1:0] i);
    logic [2:0] f;
    f = {a2, a1, a0};
    return (i == 2'd3) ? 1'b0 : f[i];
  endfunction

  // Apply the rules for the edge that follows, then queue the outputs it should produce.
  task automatic step(input string name);
    logic [1:0] idx;
    logic       emp, srs, waiting, expire;
    phase_t     n;
    exp_t       e;
    if (reset) begin
      m_ph = P_DA; m_addr = 2'd0; m_wait = 0; m_terr = 1'b0;
    end else begin
      idx     = (m_ph == P_DA) ? data_in : m_addr;
      emp     = pick(fifo_empty_0, fifo_empty_1, fifo_empty_2, idx);
      srs     = pick(soft_reset_0, soft_reset_1, soft_reset_2, idx);
      waiting = (m_ph == P_WTE) || (m_ph == P_FFS);
`ifdef ROUTER_FSM_TIMEOUT_EN
      expire  = waiting && (m_wait >= TO);
`else
      expire  = 1'b0;
`endif
      m_terr  = 1'b0;
      n       = m_ph;
      if (m_ph == P_DA && pkt_valid) m_addr = data_in;
      if (m_ph != P_DA && srs) n = P_DA;
      else if (expire) begin n = P_DA; m_terr = 1'b1; end
      else begin
        case (m_ph)
          P_DA:  if (pkt_valid && data_in != 2'd3) n = emp ? P_LFD : P_WTE;
          P_LFD: n = P_LD;
          P_LD:  n = fifo_full ? P_FFS : (!pkt_valid ? P_LP : P_LD);
          P_FFS: n = fifo_full ? P_FFS : P_LAF;
          P_LAF: n = parity_done ? P_DA : (low_pkt_valid ? P_LP : P_LD);
          P_LP:  n = P_CPE;
          P_CPE: n = fifo_full ? P_FFS : P_DA;
          P_WTE: n = emp ? P_LFD : P_WTE;
          default: n = P_DA;
        endcase
      end
      m_wait = waiting ? ((m_wait < TO) ? m_wait + 1 : m_wait) : 0;
      m_ph   = n;
    end
    e.outs = expect_outs(m_ph, m_terr);
    e.name = name;
    sb.push_back(e);
    @(negedge clock);
  endtask

  initial begin : monitor
    exp_t       e;
    logic [8:0] got;
    forever begin
      @(posedge clock);
      #1;
      cyc++;
      if (sb.size() > 0) begin
        e   = sb.pop_front();
        got = {detect_add, lfd_state, ld_state, laf_state, full_state,
               write_enb_reg, rst_int_reg, busy, timeout_err};
        total_cnt++;
        if (got === e.outs) pass_cnt++;
        else $display("FAIL %s cycle %0d: outputs got %b want %b (da,lfd,ld,laf,full,we,rst,busy,terr)",
                      e.name, cyc, got, e.outs);
      end
    end
  end

  task automatic idle_inputs();
    pkt_valid = 0; data_in = 0; parity_done = 0; low_pkt_valid = 0; fifo_full = 0;
    fifo_empty_0 = 1; fifo_empty_1 = 1; fifo_empty_2 = 1;
    soft_reset_0 = 0; soft_reset_1 = 0; soft_reset_2 = 0;
  endtask

  initial begin : stimulus
    reset = 1'b1;
    idle_inputs();
    @(negedge clock);

    step("reset0"); step("reset1");
    reset = 1'b0;

    // Normal packet to port 1 with four payload cycles.
    pkt_valid = 1; data_in = 1; fifo_empty_1 = 1;
    step("p1_lfd");
    data_in = 0;
    for (int i = 0; i < 4; i++) step("p1_ld");
    pkt_valid = 0;
    step("p1_lp"); step("p1_cpe"); step("p1_da");

    // FIFO full during payload, recovered with low_pkt_valid.
    pkt_valid = 1; data_in = 0;
    step("full_lfd"); step("full_ld");
    fifo_full = 1; step("full_ffs"); step("full_ffs_hold");
    fifo_full = 0; low_pkt_valid = 1; parity_done = 0; pkt_valid = 0;
    step("full_laf"); step("full_lp");
    low_pkt_valid = 0;
    step("full_cpe"); step("full_da");

    // Destination busy: wait in WTE until port 2 drains.
    pkt_valid = 1; data_in = 2; fifo_empty_2 = 0;
    step("wte_enter");
    for (int i = 0; i < 10; i++) step("wte_hold");
    fifo_empty_2 = 1; step("wte_lfd");
    step("wte_ld"); pkt_valid = 0; step("wte_lp"); step("wte_cpe"); step("wte_da");

    // Invalid address is ignored.
    pkt_valid = 1; data_in = 3;
    for (int i = 0; i < 3; i++) step("addr3");

    // Soft reset: non-selected port ignored, selected port aborts.
    data_in = 1;
    step("sr_lfd"); step("sr_ld");
    soft_reset_0 = 1; step("sr0_ignored");
    soft_reset_0 = 0; soft_reset_1 = 1; step("sr1_abort");
    soft_reset_1 = 0; pkt_valid = 0; step("sr_idle");

    // Reset in the middle of a packet.
    pkt_valid = 1; data_in = 2;
    step("mid_lfd"); step("mid_ld");
    reset = 1; step("mid_reset");
    reset = 0; pkt_valid = 0; step("mid_idle");

`ifdef ROUTER_FSM_TIMEOUT_EN
    pkt_valid = 1; data_in = 0; fifo_empty_0 = 0;
    step("to_enter"); pkt_valid = 0;
    for (int i = 0; i < TO + 3; i++) step("to_wait");
    fifo_empty_0 = 1;
    step("to_after");
`endif

    // Random traffic against the reference model.
    for (int i = 0; i < 3000; i++) begin
      reset         = ($urandom_range(0, 63) == 0);
      pkt_valid     = ($urandom_range(0, 3) != 0);
      data_in       = 2'($urandom_range(0, 3));
      parity_done   = ($urandom_range(0, 3) == 0);
      low_pkt_valid = ($urandom_range(0, 3) == 0);
      fifo_full     = ($urandom_range(0, 3) == 0);
      fifo_empty_0  = ($urandom_range(0, 2) != 0);
      fifo_empty_1  = ($urandom_range(0, 2) != 0);
      fifo_empty_2  = ($urandom_range(0, 9) == 0);
      soft_reset_0  = ($urandom_range(0, 31) == 0);
      soft_reset_1  = ($urandom_range(0, 31) == 0);
      soft_reset_2  = ($urandom_range(0, 31) == 0);
      step("random");
    end

    idle_inputs();
    reset = 0;
    @(negedge clock);
    total_cnt++;
    if (sb.size() == 0) pass_cnt++;
    else $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
